// File: rtl/operand2_sequencer_pkg.sv
// Shared definitions for the operand-2 sequencer and its barrel shifter:
// datapath sizing, ARM shift-type codes and a rotate helper.
package operand2_sequencer_pkg;

  localparam int WORD_W = 32;
  localparam int AMT_W  = 5;

  // Shift-type codes as encoded in instruction bits [6:5].
  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  // Rotate a word right by 0..31 positions.
  function automatic logic [WORD_W-1:0] ror_word(input logic [WORD_W-1:0] val,
                                                 input logic [AMT_W-1:0]  amt);
    logic [2*WORD_W-1:0] dbl_s;
    dbl_s = {val, val} >> amt;
    return dbl_s[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/operand2_sequencer_barrel_shifter.sv
// Plain barrel shifter for amounts 1..31. All encoding special cases
// (zero amounts, 32 and above, RRX) are resolved by the sequencer, so the
// zero-amount results of this block are never selected.
module barrel_shifter
  import operand2_sequencer_pkg::*;
#(
  parameter int WordWidth = WORD_W
) (
  input  logic [WordWidth-1:0] in_data,
  input  shift_type_e          in_type,
  input  logic [AMT_W-1:0]     in_amount,
  output logic [WordWidth-1:0] out_data,
  output logic                 out_carry
);

  logic [WordWidth:0] lsl_s;
  logic [WordWidth:0] lsr_s;
  logic [WordWidth:0] asr_s;

  // One-bit-wide guard positions capture the last bit shifted out as carry.
  always_comb begin
    lsl_s     = {1'b0, in_data} << in_amount;
    lsr_s     = {in_data, 1'b0} >> in_amount;
    asr_s     = $signed({in_data, 1'b0}) >>> in_amount;
    out_data  = {WordWidth{1'b0}};
    out_carry = 1'b0;
    case (in_type)
      SHIFT_LSL: begin
        out_data  = lsl_s[WordWidth-1:0];
        out_carry = lsl_s[WordWidth];
      end
      SHIFT_LSR: begin
        out_data  = lsr_s[WordWidth:1];
        out_carry = lsr_s[0];
      end
      SHIFT_ASR: begin
        out_data  = asr_s[WordWidth:1];
        out_carry = asr_s[0];
      end
      SHIFT_ROR: begin
        out_data  = ror_word(in_data, in_amount);
        out_carry = out_data[WordWidth-1];
      end
      default: begin
        out_data  = {WordWidth{1'b0}};
        out_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/operand2_sequencer.sv
// Operand-2 front end: fetches Rm (and Rs for register-specified shifts)
// through a one-cycle-latency read port, resolves every shift-encoding
// special case and presents a registered operand/carry pair to the ALU.
module operand2_sequencer
  import operand2_sequencer_pkg::*;
#(
  parameter int WordWidth = WORD_W
) (
  input  logic                 in_Clk,
  input  logic                 in_Rst_N,
  input  logic                 in_Valid,
  output logic                 out_Ready,
  input  logic                 in_Imm_flag,
  input  logic [11:0]          in_Op2_field,
  input  logic                 in_C_flag,
  output logic                 out_Rf_Req,
  output logic [3:0]           out_Rf_Addr,
  input  logic [WordWidth-1:0] in_Rf_Data,
  output logic                 out_Valid,
  input  logic                 in_Ready,
  output logic [WordWidth-1:0] out_Op2,
  output logic                 out_Carry
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_RM = 3'd1,
    ST_RD_RS = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [WordWidth-1:0] ZERO_WORD = {WordWidth{1'b0}};

  state_e                 state_r, next_s;
  logic [11:0]            field_r;
  logic                   imm_r;
  logic                   c_r;
  logic [WordWidth-1:0]   rm_r;
  logic [WordWidth-1:0]   op2_r;
  logic                   carry_r;
  logic                   valid_r;
  logic                   ready_r;
  logic                   req_r;
  logic [3:0]             addr_r;

  logic                   accept_s;
  logic                   req_s;
  logic [3:0]             addr_s;
  shift_type_e            type_s;
  logic [WordWidth-1:0]   rm_s;
  logic                   rm_msb_s;
  logic [WordWidth-1:0]   sign_fill_s;
  logic [7:0]             rs_amt_s;
  logic [AMT_W-1:0]       bs_amt_s;
  logic [WordWidth-1:0]   bs_data_s;
  logic                   bs_carry_s;
  logic [AMT_W-1:0]       imm_rot_amt_s;
  logic [WordWidth-1:0]   imm_val_s;
  logic [WordWidth-1:0]   imm_rot_s;
  logic [WordWidth-1:0]   res_op2_s;
  logic                   res_carry_s;

  assign out_Ready   = ready_r;
  assign out_Rf_Req  = req_r;
  assign out_Rf_Addr = addr_r;
  assign out_Valid   = valid_r;
  assign out_Op2     = op2_r;
  assign out_Carry   = carry_r;

  // Next-state selection and the registered read-port controls derived from it.
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_Valid) begin
          accept_s = 1'b1;
          next_s   = in_Imm_flag ? ST_EXEC : ST_RD_RM;
        end else begin
          next_s   = ST_IDLE;
        end
      end
      ST_RD_RM: next_s = field_r[4] ? ST_RD_RS : ST_EXEC;
      ST_RD_RS: next_s = ST_EXEC;
      ST_EXEC:  next_s = ST_DONE;
      ST_DONE: begin
        if (in_Ready) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_DONE;
        end
      end
      default:  next_s = ST_IDLE;
    endcase

    req_s  = 1'b0;
    addr_s = 4'h0;
    if (next_s == ST_RD_RM) begin
      req_s  = 1'b1;
      addr_s = in_Op2_field[3:0];
    end else if (next_s == ST_RD_RS) begin
      req_s  = 1'b1;
      addr_s = field_r[11:8];
    end else begin
      req_s  = 1'b0;
      addr_s = 4'h0;
    end
  end

  // Operand selection: Rm arrives live for immediate-amount shifts, or was
  // captured in RD_RS when Rs is the word on the read port during EXEC.
  always_comb begin
    type_s        = shift_type_e'(field_r[6:5]);
    rm_s          = field_r[4] ? rm_r : in_Rf_Data;
    rm_msb_s      = rm_s[WordWidth-1];
    sign_fill_s   = {WordWidth{rm_s[WordWidth-1]}};
    rs_amt_s      = in_Rf_Data[7:0];
    bs_amt_s      = field_r[4] ? rs_amt_s[4:0] : field_r[11:7];
    imm_rot_amt_s = {field_r[11:8], 1'b0};
    imm_val_s     = {{(WordWidth-8){1'b0}}, field_r[7:0]};
    imm_rot_s     = ror_word(imm_val_s, imm_rot_amt_s);
  end

  barrel_shifter #(
    .WordWidth (WordWidth)
  ) u_barrel_shifter (
    .in_data   (rm_s),
    .in_type   (type_s),
    .in_amount (bs_amt_s),
    .out_data  (bs_data_s),
    .out_carry (bs_carry_s)
  );

  // Special-case resolution; only plain 1..31 shifts take the shifter result.
  always_comb begin
    res_op2_s   = ZERO_WORD;
    res_carry_s = 1'b0;
    if (imm_r) begin
      if (imm_rot_amt_s == 5'd0) begin
        res_op2_s   = imm_val_s;
        res_carry_s = c_r;
      end else begin
        res_op2_s   = imm_rot_s;
        res_carry_s = imm_rot_s[WordWidth-1];
      end
    end else if (!field_r[4]) begin
      if (field_r[11:7] == 5'd0) begin
        case (type_s)
          SHIFT_LSL: begin res_op2_s = rm_s;        res_carry_s = c_r;      end
          SHIFT_LSR: begin res_op2_s = ZERO_WORD;   res_carry_s = rm_msb_s; end
          SHIFT_ASR: begin res_op2_s = sign_fill_s; res_carry_s = rm_msb_s; end
          SHIFT_ROR: begin
            res_op2_s   = {c_r, rm_s[WordWidth-1:1]};
            res_carry_s = rm_s[0];
          end
          default:   begin res_op2_s = rm_s;        res_carry_s = c_r;      end
        endcase
      end else begin
        res_op2_s   = bs_data_s;
        res_carry_s = bs_carry_s;
      end
    end else begin
      if (rs_amt_s == 8'd0) begin
        res_op2_s   = rm_s;
        res_carry_s = c_r;
      end else if (rs_amt_s < 8'd32) begin
        res_op2_s   = bs_data_s;
        res_carry_s = bs_carry_s;
      end else if (rs_amt_s == 8'd32) begin
        case (type_s)
          SHIFT_LSL: begin res_op2_s = ZERO_WORD;   res_carry_s = rm_s[0];  end
          SHIFT_LSR: begin res_op2_s = ZERO_WORD;   res_carry_s = rm_msb_s; end
          SHIFT_ASR: begin res_op2_s = sign_fill_s; res_carry_s = rm_msb_s; end
          SHIFT_ROR: begin res_op2_s = rm_s;        res_carry_s = rm_msb_s; end
          default:   begin res_op2_s = ZERO_WORD;   res_carry_s = 1'b0;     end
        endcase
      end else begin
        case (type_s)
          SHIFT_LSL: begin res_op2_s = ZERO_WORD;   res_carry_s = 1'b0;     end
          SHIFT_LSR: begin res_op2_s = ZERO_WORD;   res_carry_s = 1'b0;     end
          SHIFT_ASR: begin res_op2_s = sign_fill_s; res_carry_s = rm_msb_s; end
          SHIFT_ROR: begin
            if (rs_amt_s[4:0] == 5'd0) begin
              res_op2_s   = rm_s;
              res_carry_s = rm_msb_s;
            end else begin
              res_op2_s   = bs_data_s;
              res_carry_s = bs_carry_s;
            end
          end
          default:   begin res_op2_s = ZERO_WORD;   res_carry_s = 1'b0;     end
        endcase
      end
    end
  end

  // State register plus registered handshake and read-port outputs.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      req_r   <= 1'b0;
      addr_r  <= 4'h0;
    end else begin
      state_r <= next_s;
      ready_r <= (next_s == ST_IDLE);
      valid_r <= (next_s == ST_DONE);
      req_r   <= req_s;
      addr_r  <= addr_s;
    end
  end

  // Request capture at acceptance; C and the field are frozen for the job.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      field_r <= 12'h000;
      imm_r   <= 1'b0;
      c_r     <= 1'b0;
    end else if (accept_s) begin
      field_r <= in_Op2_field;
      imm_r   <= in_Imm_flag;
      c_r     <= in_C_flag;
    end
  end

  // Rm is on the read port during RD_RS, the cycle Rs is requested.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      rm_r <= ZERO_WORD;
    end else if (state_r == ST_RD_RS) begin
      rm_r <= in_Rf_Data;
    end
  end

  // Result register: loaded once in EXEC and held through DONE and IDLE.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      op2_r   <= ZERO_WORD;
      carry_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      op2_r   <= res_op2_s;
      carry_r <= res_carry_s;
    end
  end

endmodule

// File: tb/tb_operand2_sequencer.sv
// Scoreboard bench for operand2_sequencer: a driver issues jobs and pushes
// expected results from an architectural shift model; a register-file
// responder checks read requests; a monitor checks results and handshake.
module tb_operand2_sequencer;

  logic        in_Clk = 1'b0;
  logic        in_Rst_N;
  logic        in_Valid;
  logic        out_Ready;
  logic        in_Imm_flag;
  logic [11:0] in_Op2_field;
  logic        in_C_flag;
  logic        out_Rf_Req;
  logic [3:0]  out_Rf_Addr;
  logic [31:0] in_Rf_Data;
  logic        out_Valid;
  logic        in_Ready;
  logic [31:0] out_Op2;
  logic        out_Carry;

  operand2_sequencer dut (
    .in_Clk       (in_Clk),
    .in_Rst_N     (in_Rst_N),
    .in_Valid     (in_Valid),
    .out_Ready    (out_Ready),
    .in_Imm_flag  (in_Imm_flag),
    .in_Op2_field (in_Op2_field),
    .in_C_flag    (in_C_flag),
    .out_Rf_Req   (out_Rf_Req),
    .out_Rf_Addr  (out_Rf_Addr),
    .in_Rf_Data   (in_Rf_Data),
    .out_Valid    (out_Valid),
    .in_Ready     (in_Ready),
    .out_Op2      (out_Op2),
    .out_Carry    (out_Carry)
  );

  always #5 in_Clk = ~in_Clk;

  int cyc = 0;
  always @(posedge in_Clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int forced_hold = -1;
  logic [31:0] regs [16];

  typedef struct { logic [31:0] op2; logic c; int acc; int lat; } exp_t;
  typedef struct { logic [3:0] addr; int cyc; } rd_t;
  exp_t exp_q [$];
  rd_t  rd_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Architectural shifter-operand semantics, amount treated as a plain integer.
  function automatic void ref_model(input logic imm, input logic [11:0] f, input logic c,
                                    input logic [31:0] rm, input logic [31:0] rs,
                                    output logic [31:0] op2, output logic co);
    longint unsigned v;
    int n, r, k;
    op2 = 32'h0; co = 1'b0;
    if (imm) begin
      r = 2 * int'(f[11:8]);
      v = longint'(f[7:0]);
      if (r == 0) begin op2 = v[31:0]; co = c; end
      else begin v = (v >> r) | (v << (32 - r)); op2 = v[31:0]; co = op2[31]; end
      return;
    end
    v = longint'(rm);
    if (!f[4]) begin
      n = int'(f[11:7]);
      if (n == 0) begin
        case (f[6:5])
          2'd1, 2'd2: n = 32;
          2'd3: begin op2 = {c, rm[31:1]}; co = rm[0]; return; end
          default: n = 0;
        endcase
      end
    end else begin
      n = int'(rs[7:0]);
    end
    if (n == 0) begin op2 = rm; co = c; return; end
    case (f[6:5])
      2'd0: if (n > 32) begin op2 = 32'h0; co = 1'b0; end
            else begin op2 = 32'(v << n); co = v[32 - n]; end
      2'd1: if (n > 32) begin op2 = 32'h0; co = 1'b0; end
            else begin op2 = 32'(v >> n); co = v[n - 1]; end
      2'd2: if (n >= 32) begin op2 = rm[31] ? 32'hFFFF_FFFF : 32'h0; co = rm[31]; end
            else begin op2 = 32'($signed(rm) >>> n); co = v[n - 1]; end
      default: begin
        k = n % 32;
        if (k == 0) begin op2 = rm; co = rm[31]; end
        else begin op2 = 32'((v >> k) | (v << (32 - k))); co = op2[31]; end
      end
    endcase
  endfunction

  // Issue one job; abort=1 pulls reset while the Rs read is in flight.
  task automatic issue(input logic imm, input logic [11:0] f, input logic c, input logic abort);
    logic [31:0] e_op2;
    logic        e_c;
    exp_t        e;
    rd_t         rd;
    int          n;
    ref_model(imm, f, c, regs[f[3:0]], regs[f[11:8]], e_op2, e_c);
    @(negedge in_Clk);
    in_Valid = 1'b1; in_Imm_flag = imm; in_Op2_field = f; in_C_flag = c;
    n = 0;
    while (!out_Ready && n < 50) begin @(negedge in_Clk); n++; end
    if (!out_Ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got out_Ready=0, expected 1");
      in_Valid = 1'b0;
      return;
    end
    e.op2 = e_op2; e.c = e_c; e.acc = cyc;
    e.lat = imm ? 2 : (f[4] ? 4 : 3);
    exp_q.push_back(e);
    if (!imm) begin rd.addr = f[3:0]; rd.cyc = cyc + 1; rd_q.push_back(rd); end
    if (!imm && f[4]) begin rd.addr = f[11:8]; rd.cyc = cyc + 2; rd_q.push_back(rd); end
    @(posedge in_Clk);
    #1;
    in_Valid = 1'b0;
    in_Op2_field = 12'($urandom); in_C_flag = 1'($urandom); in_Imm_flag = 1'($urandom);
    if (abort) begin
      @(negedge in_Clk);
      @(negedge in_Clk);
      #2 in_Rst_N = 1'b0;
      #1;
      chk("abort_valid", 32'(out_Valid), 32'h0);
      chk("abort_op2", out_Op2, 32'h0);
      chk("abort_carry", 32'(out_Carry), 32'h0);
      chk("abort_rf_req", 32'(out_Rf_Req), 32'h0);
      chk("abort_rf_addr", 32'(out_Rf_Addr), 32'h0);
      void'(exp_q.pop_back());
      rd_q.delete();
      @(negedge in_Clk);
      in_Rst_N = 1'b1;
      @(negedge in_Clk);
      chk("ready_after_abort", 32'(out_Ready), 32'h1);
      return;
    end
    n = 0;
    while (!out_Ready && n < 100) begin @(negedge in_Clk); n++; end
    if (!out_Ready) begin
      tests++; fails++;
      $display("FAIL job_timeout: got out_Ready=0, expected 1");
    end
  endtask

  // Register-file responder: checks each request, returns data a cycle later.
  initial begin
    logic       rq;
    logic [3:0] a;
    int         cy;
    rd_t        r;
    in_Rf_Data = 32'h0;
    forever begin
      @(negedge in_Clk);
      rq = out_Rf_Req; a = out_Rf_Addr; cy = cyc;
      if (rq && in_Rst_N) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rf_req_extra: got request addr %0d, expected none", a);
        end else begin
          r = rd_q.pop_front();
          chk("rf_addr", 32'(a), 32'(r.addr));
          chk("rf_req_cycle", 32'(cy), 32'(r.cyc));
        end
      end
      @(posedge in_Clk);
      #1;
      in_Rf_Data = rq ? regs[a] : $urandom;
    end
  end

  // Monitor: pops the scoreboard on each new result and applies backpressure.
  initial begin
    exp_t        e;
    logic        in_job;
    logic        after_hs;
    int          hold_left;
    logic [31:0] held_op2;
    logic        held_c;
    in_job = 1'b0; after_hs = 1'b0; hold_left = 0; held_op2 = 32'h0; held_c = 1'b0;
    in_Ready = 1'b0;
    forever begin
      @(negedge in_Clk);
      if (!in_Rst_N) begin
        in_job = 1'b0; after_hs = 1'b0; in_Ready = 1'b0;
      end else begin
        if (after_hs) begin
          chk("idle_gap_valid", 32'(out_Valid), 32'h0);
          chk("idle_gap_ready", 32'(out_Ready), 32'h1);
          after_hs = 1'b0;
        end
        if (out_Valid) begin
          if (!in_job) begin
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_valid: got op2 0x%08h, expected no result", out_Op2);
            end else begin
              e = exp_q.pop_front();
              chk("op2", out_Op2, e.op2);
              chk("carry", 32'(out_Carry), 32'(e.c));
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
            held_op2 = out_Op2; held_c = out_Carry; in_job = 1'b1;
            hold_left = (forced_hold >= 0) ? forced_hold : int'($urandom_range(0, 3));
          end else begin
            chk("hold_op2", out_Op2, held_op2);
            chk("hold_carry", 32'(out_Carry), 32'(held_c));
          end
          chk("ready_low_in_done", 32'(out_Ready), 32'h0);
          if (hold_left == 0) begin
            in_Ready = 1'b1; in_job = 1'b0; after_hs = 1'b1;
          end else begin
            in_Ready = 1'b0; hold_left--;
          end
        end else begin
          in_Ready = 1'($urandom);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog");
  end

  // Main stimulus: reset, directed corner cases, then randomized jobs.
  initial begin
    logic [11:0] f;
    logic [31:0] tmp;
    logic [7:0]  amt;
    int          n;
    in_Rst_N = 1'b0; in_Valid = 1'b0; in_Imm_flag = 1'b0; in_Op2_field = 12'h0; in_C_flag = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    repeat (2) @(negedge in_Clk);
    #1;
    chk("rst_valid", 32'(out_Valid), 32'h0);
    chk("rst_op2", out_Op2, 32'h0);
    chk("rst_carry", 32'(out_Carry), 32'h0);
    chk("rst_rf_req", 32'(out_Rf_Req), 32'h0);
    chk("rst_rf_addr", 32'(out_Rf_Addr), 32'h0);
    @(negedge in_Clk);
    in_Rst_N = 1'b1;
    @(negedge in_Clk);
    chk("rst_ready", 32'(out_Ready), 32'h1);

    issue(1'b1, {4'd4, 8'hFF}, 1'b0, 1'b0);
    regs[2] = 32'h8000_0001;
    issue(1'b0, {5'd0, 2'b10, 1'b0, 4'd2}, 1'b0, 1'b0);
    issue(1'b0, {5'd0, 2'b11, 1'b0, 4'd2}, 1'b1, 1'b0);
    regs[3] = 32'h0000_0003;
    regs[4] = 32'h0000_0020;
    issue(1'b0, {4'd4, 1'b0, 2'b00, 1'b1, 4'd3}, 1'b0, 1'b0);
    regs[4] = 32'h0000_0021;
    issue(1'b0, {4'd4, 1'b0, 2'b00, 1'b1, 4'd3}, 1'b0, 1'b0);
    regs[4] = 32'h0000_0000;
    issue(1'b0, {4'd4, 1'b0, 2'b00, 1'b1, 4'd3}, 1'b1, 1'b0);
    regs[5] = 32'h0000_000F;
    regs[6] = 32'h0000_0044;
    issue(1'b0, {4'd6, 1'b0, 2'b11, 1'b1, 4'd5}, 1'b0, 1'b0);
    forced_hold = 5;
    regs[7] = 32'h1234_5678;
    issue(1'b0, {5'd3, 2'b01, 1'b0, 4'd7}, 1'b0, 1'b0);
    forced_hold = -1;
    regs[9] = 32'h0000_0005;
    issue(1'b0, {4'd9, 1'b1, 2'b10, 1'b1, 4'd7}, 1'b1, 1'b1);
    issue(1'b0, {4'd9, 1'b1, 2'b10, 1'b1, 4'd7}, 1'b1, 1'b0);

    for (int j = 0; j < 150; j++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      f = 12'($urandom);
      case ($urandom_range(0, 2))
        0: issue(1'b1, f, 1'($urandom), 1'b0);
        1: issue(1'b0, f & 12'hFEF, 1'($urandom), 1'b0);
        default: begin
          f = f | 12'h010;
          case ($urandom_range(0, 5))
            0: amt = 8'd0;
            1: amt = 8'(32);
            2: amt = 8'($urandom_range(33, 255));
            3: amt = 8'h40 + 8'($urandom_range(0, 1)) * 8'h20;
            default: amt = 8'($urandom_range(1, 31));
          endcase
          tmp = $urandom;
          regs[f[11:8]] = {tmp[31:8], amt};
          issue(1'b0, f, 1'($urandom), 1'b0);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge in_Clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge in_Clk); n++; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("rf_reads_drained", 32'(rd_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand2_sequencer.md
# operand2_sequencer

Multi-cycle front end for the data-processing operand-2 path. Takes the I bit and 12-bit shifter-operand field of an instruction, fetches Rm and, for register-specified shifts, Rs over a one-cycle-latency register-file read port. Resolves every ARM shift-encoding special case itself and returns a registered `out_Op2`/`out_Carry` pair to the ALU stage over a valid/ready handshake. Only plain shifts of 1–31 go to an internal `barrel_shifter`.

## Interface
Parameters:
- `WordWidth`, from `Def_StructureParameter.v` (32): datapath width.

Ports:
- `in_Clk`  in  1  sole clock; all state changes on rising edge.
- `in_Rst_N`  in  1  asynchronous, active-low reset.
- `in_Valid`  in  1  request present.
- `out_Ready`  out  1  block can accept; high only in IDLE.
- `in_Imm_flag`  in  1  instruction bit 25 (1 = rotated immediate).
- `in_Op2_field`  in  12  instruction bits [11:0].
- `in_C_flag`  in  1  CPSR C; sampled at acceptance.
- `out_Rf_Req`  out  1  register read request.
- `out_Rf_Addr`  out  4  register index.
- `in_Rf_Data`  in  WordWidth  read data; valid the cycle after `out_Rf_Req`.
- `out_Valid`  out  1  result valid.
- `in_Ready`  in  1  consumer accepts result.
- `out_Op2`  out  WordWidth  shifted operand.
- `out_Carry`  out  1  shifter carry-out.

## Operation
- States: IDLE, RD_RM, RD_RS, EXEC, DONE.
- IDLE: `out_Ready`=1. When `in_Valid`=1, latch the field, I bit and C.
  - Immediate → EXEC.
  - Otherwise → RD_RM.
- RD_RM: `out_Rf_Req`=1, `out_Rf_Addr`=field[3:0].
  - field[4]=1 → RD_RS.
  - field[4]=0 → EXEC.
- RD_RS: latch Rm from `in_Rf_Data`; issue Rs (`out_Rf_Addr`=field[11:8]); → EXEC. field[7] is ignored.
- EXEC: latch the pending read data (Rm, or Rs[7:0] as amount); compute; register result; → DONE.
- DONE: `out_Valid`=1, outputs held stable until `in_Ready`=1, then → IDLE.
- Immediate path:
  - val = zero-extended field[7:0]; rotate right by 2·field[11:8].
  - rot=0: op2=val, carry=C.
  - Otherwise: carry=op2[31].
- Register, immediate amount (type=field[6:5], amt=field[11:7]):
  - LSL#0: op2=Rm, carry=C.
  - LSR#0 means LSR#32: op2=0, carry=Rm[31].
  - ASR#0 means ASR#32: op2 = all bits Rm[31], carry=Rm[31].
  - ROR#0 means RRX: op2={C,Rm[31:1]}, carry=Rm[0].
  - 1–31: `barrel_shifter`.
- Register, register amount (amt=Rs[7:0]):
  - amt=0: op2=Rm, carry=C for all types.
  - amt 1–31: `barrel_shifter`.
  - amt=32:
    - LSL: 0, carry Rm[0].
    - LSR: 0, carry Rm[31].
    - ASR: sign-fill, carry Rm[31].
    - ROR: Rm, carry Rm[31].
  - amt>32:
    - LSL/LSR: 0, carry 0.
    - ASR: same as 32.
    - ROR with amt[4:0]=0: same as 32.
    - ROR with amt[4:0]≠0: rotate by amt[4:0].
- ASR fill is always the full word of Rm[31], never the value 1.
- `in_Rf_Data` is ignored outside the capture cycles. `in_C_flag` is ignored after acceptance.

## Timing
- Reset values: state IDLE, `out_Valid`=0, `out_Op2`=0, `out_Carry`=0, `out_Rf_Req`=0, `out_Rf_Addr`=0. `out_Ready`=1 once reset is released.
- Latency from the accepting edge to `out_Valid` high:
  - immediate: 2 cycles.
  - register/imm-amount: 3 cycles.
  - register/register: 4 cycles.
- DONE with `in_Ready`=1: returns to IDLE. No new acceptance that same cycle, so there is one idle cycle between jobs.
- `out_Rf_Req` is high exactly one cycle per register read.
- Reset asserted mid-operation: job aborted immediately, no output produced, all outputs go to reset values.
- Backpressure: DONE may last indefinitely; result and carry do not change while in DONE.

## Structure
- Shift-type codes (LSL=00, LSR=01, ASR=10, ROR=11) move to a shared `Def_Shift.v` include, used by this block and `barrel_shifter`.
- FSM state encodings stay local.
- One sub-module: a `barrel_shifter` instance, driven only for amounts 1–31, with its zero-amount paths never selected.
- Special-case resolution, rotated-immediate logic and the output register live in this block.

## Test plan
- Immediate 0xFF, rot=4, C=0 → op2=0xFF000000, carry=1, `out_Valid` 2 cycles after acceptance.
- Rm=0x80000001, ASR#0 (imm encoding) → op2=0xFFFFFFFF, carry=1; same Rm with ROR#0 and C=1 → op2=0xC0000000, carry=1.
- Register shift LSL by Rs=0x20, Rm=0x00000003 → op2=0, carry=1; Rs=0x21 → op2=0, carry=0; Rs=0x00, C=1 → op2=Rm, carry=1.
- ROR by Rs=0x44, Rm=0x0000000F → op2=0xF0000000, carry=1; read port shows Rm then Rs requests on consecutive cycles, result 4 cycles after acceptance.
- Hold `in_Ready`=0 for 5 cycles in DONE → outputs stable, `out_Ready`=0 throughout, then one idle cycle before the next accept.
- Assert `in_Rst_N` low during RD_RS → all outputs at reset values immediately; the next request completes normally.
